// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encoding for the multi-cycle divider
package div_unit_pkg;
  typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_e;
endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for DIV/DIVU returning {remainder, quotient}
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_e         r_state, w_state;
  logic [2*WIDTH-1:0] r_work, w_work, r_result, w_result;
  logic [2*WIDTH:0]   w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   r_divisor, w_divisor, w_mag1, w_mag2, w_quo, w_rem;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic               r_signed, w_signed, r_neg1, w_neg1, r_neg2, w_neg2, r_ready, w_ready;
  // operand magnitudes, one restoring step, and sign fix-up of the finished work register
  always_comb begin
    w_mag1  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    w_mag2  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    w_shift = {r_work, 1'b0};
    w_trial = w_shift[2*WIDTH:WIDTH] - {1'b0, r_divisor};
    w_quo   = (r_signed && (r_neg1 ^ r_neg2)) ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
    w_rem   = (r_signed && r_neg1) ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];
  end
  // next state, datapath and output values; everything holds unless a state says otherwise
  always_comb begin
    w_state   = r_state;
    w_work    = r_work;
    w_divisor = r_divisor;
    w_cnt     = r_cnt;
    w_signed  = r_signed;
    w_neg1    = r_neg1;
    w_neg2    = r_neg2;
    w_ready   = 1'b0;
    w_result  = '0;
    case (r_state)
      DIV_FREE: if (start_i && !annul_i) begin
        w_state   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        w_work    = {{WIDTH{1'b0}}, w_mag1};
        w_divisor = w_mag2;
        w_signed  = signed_div_i;
        w_neg1    = opdata1_i[WIDTH-1];
        w_neg2    = opdata2_i[WIDTH-1];
        w_cnt     = '0;
      end
      DIV_BYZERO: begin
        w_state = annul_i ? DIV_FREE : DIV_END;
        w_work  = '0;
      end
      DIV_ON: if (annul_i) w_state = DIV_FREE;
      else begin
        w_work  = w_trial[WIDTH] ? w_shift[2*WIDTH-1:0] : {w_trial[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};
        w_cnt   = r_cnt + CW'(1);
        w_state = (r_cnt == CW'(WIDTH - 1)) ? DIV_END : DIV_ON;
      end
      DIV_END: if (start_i) begin
        w_ready  = 1'b1;
        w_result = {w_rem, w_quo};
      end else w_state = DIV_FREE;
      default: w_state = DIV_FREE;
    endcase
  end
  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_work    <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state;
      r_work    <= w_work;
      r_divisor <= w_divisor;
      r_cnt     <= w_cnt;
      r_signed  <= w_signed;
      r_neg1    <= w_neg1;
      r_neg2    <= w_neg2;
      r_ready   <= w_ready;
      r_result  <= w_result;
    end
  end
  assign ready_o  = r_ready;
  assign result_o = r_result;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus corner sequences for div_unit
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready_o) break;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
    end
  endtask

  task automatic do_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold);
    int cyc;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    wait_ready(cyc);
    check({name, "_latency"}, 64'(cyc), (b == 32'd0) ? 64'd3 : 64'd34);
    check({name, "_result"}, result_o, exp);
    for (int h = 0; h < hold; h++) begin
      opdata1_i = ~a; opdata2_i = 32'd3; signed_div_i = ~s;
      @(posedge clk); #1;
      check($sformatf("%s_hold%0d", name, h), {ready_o, result_o}, {1'b1, exp});
    end
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    check({name, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({name, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic expect_silence(input string name);
    logic seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ready_o || result_o != '0) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,        32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,        32'hFFFFFFFD}};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,        32'h80000000}};
    vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0}};
    vecs[5]  = '{1'b0, 32'h12345678,   32'd0,          64'd0};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          64'd0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,        32'hFFFFFFFF}};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14}};
    vecs[9]  = '{1'b0, 32'd5,          32'd9,          {32'd5,        32'd0}};
    vecs[10] = '{1'b1, 32'd100,        32'hFFFFFFF9,   {32'd2,        32'hFFFFFFF2}};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,        32'd1}};

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_div($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    do_div("hold5", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 5);

    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk); annul_i = 1'b0;
    expect_silence("annul_no_ready");
    do_div("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk); annul_i = 1'b0;
    expect_silence("annul_byzero_no_ready");

    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("rst_on_ready", 64'(ready_o), 64'd0);
    check("rst_on_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;
    expect_silence("rst_on_no_ready");

    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    wait_ready(cyc);
    check("rst_end_pre_result", result_o, {32'd2, 32'd14});
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    do_div("after_rst", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
